morse_rx: RTL and testbench
===========================

Name: morse_rx

Overview:
- Receive side of the team's Morse pulse-pattern link: captures a 12-bit flash frame from the serial DotDash line, one bit per NewBit strobe.
- Decodes the frame back to the 3-bit letter code and flags frames that match no letter or that stall mid-frame.
- Connects directly to the transmitter's DotDashOut/NewBitOut outputs, or to any source driving the same strobe/data pair.

Parameters:
- CLOCK_FREQUENCY, 500, clock cycles per second; the stall timeout is CLOCK_FREQUENCY cycles, i.e. two nominal bit periods.

Ports:
- ClockIn  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
- Arm  input  1  one-cycle pulse; starts capture of a new frame.
- DotDashIn  input  1  serial flash bit; 1 = light on.
- NewBitIn  input  1  one-cycle strobe; DotDashIn is valid in the same cycle.
- Letter  output  3  decoded letter code, held until the next decode.
- Valid  output  1  one-cycle pulse; Letter updated.
- Error  output  1  one-cycle pulse; frame rejected.
- ErrCode  output  2  00 none, 01 no match, 10 timeout; held until the next Valid or Error.
- Busy  output  1  high in CAPTURE and DECODE.
- BitCount  output  4  bits captured in the current frame, 0..12.

Behaviour:
- Reset=0 (asynchronous) -> state IDLE; Letter=0, Valid=0, Error=0, ErrCode=00, Busy=0, BitCount=0; shift register and timer cleared.
- FSM states and transitions:
  - IDLE -> CAPTURE on Arm.
  - CAPTURE -> DECODE when the 12th bit is captured.
  - CAPTURE -> IDLE on timeout.
  - DECODE -> IDLE after one cycle.
- CAPTURE bit sampling:
  - Each NewBitIn=1 shifts DotDashIn into the LSB of a 12-bit register, MSB first.
  - Each capture increments BitCount.
- Arm in any state other than DECODE:
  - Clears the register and BitCount, reloads the timer, enters CAPTURE.
  - Arm and NewBitIn in the same cycle: Arm wins and that bit is discarded.
- Arm during DECODE is ignored.
- NewBitIn in IDLE or DECODE is ignored.
- Timer:
  - Loaded with CLOCK_FREQUENCY on Arm and on every captured bit.
  - Decrements each cycle while in CAPTURE.
  - Reaching 0 -> Error pulse, ErrCode=10, state IDLE, BitCount=0.
  - Timer width is $clog2(CLOCK_FREQUENCY)+1 bits.
- Latency:
  - 12th bit captured on edge E -> DECODE during the cycle after E.
  - On edge E+1, Letter, Valid or Error, and ErrCode are registered; the pulse is high for exactly the cycle following E+1.
- Decode table (exact 12-bit match, MSB = first bit received):
  - 0 = 101110000000
  - 1 = 111010101000
  - 2 = 111010111010
  - 3 = 111010100000
  - 4 = 100000000000
  - 5 = 010101110100
  - 6 = 111011101000
  - 7 = 101010100000
- Match -> Valid=1, Letter=code, ErrCode=00. No match -> Error=1, ErrCode=01, Letter unchanged.
- Valid and Error are never high together.
- Busy is combinational from state.
- After DECODE, no new capture starts without a fresh Arm.

Test Plan:
1. Reset low mid-CAPTURE with BitCount=5 -> all outputs 0 within the same cycle. Release Reset, then send NewBitIn strobes -> BitCount stays 0 and nothing is captured.
2. Arm, then 12 strobes spaced 250 cycles carrying 111010111010 -> on the 12th strobe at edge E, Valid=1 in the cycle after E+1, Letter=2, ErrCode=00. Busy falls the same cycle Valid rises.
3. Arm, then 12 strobes carrying 110000000000 -> Error=1, ErrCode=01, Letter retains its previous value (2), Valid stays 0.
4. Arm, 4 strobes, then silence -> Error=1 with ErrCode=10 exactly 500 cycles after the 4th strobe. State returns to IDLE and BitCount=0.
5. Arm, 6 strobes, then Arm coincident with a strobe, then 12 strobes carrying 100000000000 -> Letter=4, Valid=1. The coincident bit is not counted: BitCount reaches 12 only on the 12th post-Arm strobe.
6. All eight codes sent back-to-back, with Arm issued 2 cycles after each Valid -> Letter sequence 0..7, eight Valid pulses, zero Error pulses.

Source files
------------

// File: rtl/morse_rx_if.sv
// rtl/morse_rx_if.sv - strobe/data input pair and decode results of the Morse receiver
interface morse_rx_if;
  logic       Arm;
  logic       DotDashIn;
  logic       NewBitIn;
  logic [2:0] Letter;
  logic       Valid;
  logic       Error;
  logic [1:0] ErrCode;
  logic       Busy;
  logic [3:0] BitCount;

  modport master (
    output Arm, DotDashIn, NewBitIn,
    input  Letter, Valid, Error, ErrCode, Busy, BitCount
  );

  modport slave (
    input  Arm, DotDashIn, NewBitIn,
    output Letter, Valid, Error, ErrCode, Busy, BitCount
  );
endinterface

// File: rtl/morse_rx.sv
// rtl/morse_rx.sv - captures a 12-bit flash frame and decodes it to a 3-bit letter code
module morse_rx #(
  parameter int CLOCK_FREQUENCY = 500
) (
  input  logic        ClockIn,
  input  logic        Reset,
  morse_rx_if.slave   bus
);

  localparam int TW = $clog2(CLOCK_FREQUENCY) + 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLOCK_FREQUENCY);

  typedef enum logic [1:0] {IDLE, CAPTURE, DECODE} state_t;

  state_t        state;
  logic [11:0]   shift;
  logic [TW-1:0] timer;
  logic [2:0]    code;
  logic          hit;

  always_comb begin
    code = 3'd0;
    hit  = 1'b1;
    case (shift)
      12'b101110000000: code = 3'd0;
      12'b111010101000: code = 3'd1;
      12'b111010111010: code = 3'd2;
      12'b111010100000: code = 3'd3;
      12'b100000000000: code = 3'd4;
      12'b010101110100: code = 3'd5;
      12'b111011101000: code = 3'd6;
      12'b101010100000: code = 3'd7;
      default:          hit  = 1'b0;
    endcase
  end

  assign bus.Busy = (state == CAPTURE) || (state == DECODE);

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      shift        <= '0;
      timer        <= '0;
      bus.Letter   <= 3'd0;
      bus.Valid    <= 1'b0;
      bus.Error    <= 1'b0;
      bus.ErrCode  <= 2'b00;
      bus.BitCount <= 4'd0;
    end else begin
      bus.Valid <= 1'b0;
      bus.Error <= 1'b0;
      case (state)
        IDLE, CAPTURE: begin
          // Arm restarts the frame and swallows any strobe in the same cycle
          if (bus.Arm) begin
            shift        <= '0;
            bus.BitCount <= 4'd0;
            timer        <= TIMER_LOAD;
            state        <= CAPTURE;
          end else if (state == CAPTURE) begin
            if (bus.NewBitIn) begin
              shift        <= {shift[10:0], bus.DotDashIn};
              bus.BitCount <= bus.BitCount + 4'd1;
              timer        <= TIMER_LOAD;
              if (bus.BitCount == 4'd11)
                state <= DECODE;
            end else if (timer == TW'(1)) begin
              timer        <= '0;
              bus.Error    <= 1'b1;
              bus.ErrCode  <= 2'b10;
              bus.BitCount <= 4'd0;
              state        <= IDLE;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        DECODE: begin
          if (hit) begin
            bus.Valid   <= 1'b1;
            bus.Letter  <= code;
            bus.ErrCode <= 2'b00;
          end else begin
            bus.Error   <= 1'b1;
            bus.ErrCode <= 2'b01;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_rx.sv
// tb/tb_morse_rx.sv - directed bench for morse_rx
module tb_morse_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   valid_seen = 0;
  int   error_seen = 0;

  morse_rx_if bus ();

  morse_rx dut (
    .ClockIn (clk),
    .Reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.Valid === 1'b1) valid_seen++;
    if (bus.Error === 1'b1) error_seen++;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic arm();
    bus.Arm = 1'b1;
    @(negedge clk);
    bus.Arm = 1'b0;
  endtask

  task automatic strobe(input logic b);
    bus.NewBitIn  = 1'b1;
    bus.DotDashIn = b;
    @(negedge clk);
    bus.NewBitIn  = 1'b0;
    bus.DotDashIn = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] f, input int gap);
    for (int i = 11; i >= 0; i--) begin
      strobe(f[i]);
      if (i != 0) repeat (gap) @(negedge clk);
    end
  endtask

  logic [11:0] table_codes [8];
  logic [11:0] tmp;

  initial begin
    table_codes[0] = 12'b101110000000;
    table_codes[1] = 12'b111010101000;
    table_codes[2] = 12'b111010111010;
    table_codes[3] = 12'b111010100000;
    table_codes[4] = 12'b100000000000;
    table_codes[5] = 12'b010101110100;
    table_codes[6] = 12'b111011101000;
    table_codes[7] = 12'b101010100000;

    bus.Arm = 1'b0; bus.NewBitIn = 1'b0; bus.DotDashIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_letter", {9'd0, bus.Letter}, 12'd0);
    chk("rst_busy", {11'd0, bus.Busy}, 12'd0);
    chk("rst_errcode", {10'd0, bus.ErrCode}, 12'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: asynchronous reset mid-capture
    arm();
    for (int i = 0; i < 5; i++) strobe(1'b1);
    chk("t1_bitcount5", {8'd0, bus.BitCount}, 12'd5);
    chk("t1_busy", {11'd0, bus.Busy}, 12'd1);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_bitcount", {8'd0, bus.BitCount}, 12'd0);
    chk("t1_async_busy", {11'd0, bus.Busy}, 12'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    chk("t1_idle_bitcount", {8'd0, bus.BitCount}, 12'd0);
    chk("t1_idle_busy", {11'd0, bus.Busy}, 12'd0);

    // 2: letter 2 with 250-cycle spacing
    arm();
    tmp = 12'b111010111010;
    send_frame(tmp, 249);
    chk("t2_decode_busy", {11'd0, bus.Busy}, 12'd1);
    chk("t2_decode_valid", {11'd0, bus.Valid}, 12'd0);
    @(negedge clk);
    chk("t2_valid", {11'd0, bus.Valid}, 12'd1);
    chk("t2_letter", {9'd0, bus.Letter}, 12'd2);
    chk("t2_errcode", {10'd0, bus.ErrCode}, 12'd0);
    chk("t2_busy_fall", {11'd0, bus.Busy}, 12'd0);
    @(negedge clk);
    chk("t2_valid_pulse", {11'd0, bus.Valid}, 12'd0);

    // 3: no match
    arm();
    tmp = 12'b110000000000;
    send_frame(tmp, 3);
    @(negedge clk);
    chk("t3_error", {11'd0, bus.Error}, 12'd1);
    chk("t3_errcode", {10'd0, bus.ErrCode}, 12'd1);
    chk("t3_letter_kept", {9'd0, bus.Letter}, 12'd2);
    chk("t3_valid", {11'd0, bus.Valid}, 12'd0);
    @(negedge clk);
    chk("t3_error_pulse", {11'd0, bus.Error}, 12'd0);

    // 4: stall timeout 500 cycles after the 4th strobe
    arm();
    for (int i = 0; i < 4; i++) strobe(1'b1);
    repeat (499) @(negedge clk);
    chk("t4_not_yet", {11'd0, bus.Error}, 12'd0);
    chk("t4_still_busy", {11'd0, bus.Busy}, 12'd1);
    @(negedge clk);
    chk("t4_error", {11'd0, bus.Error}, 12'd1);
    chk("t4_errcode", {10'd0, bus.ErrCode}, 12'd2);
    chk("t4_bitcount", {8'd0, bus.BitCount}, 12'd0);
    chk("t4_idle", {11'd0, bus.Busy}, 12'd0);

    // 5: Arm wins over a coincident strobe
    arm();
    for (int i = 0; i < 6; i++) strobe(1'b1);
    bus.Arm = 1'b1; bus.NewBitIn = 1'b1; bus.DotDashIn = 1'b1;
    @(negedge clk);
    bus.Arm = 1'b0; bus.NewBitIn = 1'b0; bus.DotDashIn = 1'b0;
    chk("t5_rearm_count", {8'd0, bus.BitCount}, 12'd0);
    tmp = 12'b100000000000;
    for (int i = 11; i >= 1; i--) strobe(tmp[i]);
    chk("t5_count11", {8'd0, bus.BitCount}, 12'd11);
    strobe(tmp[0]);
    chk("t5_count12", {8'd0, bus.BitCount}, 12'd12);
    @(negedge clk);
    chk("t5_valid", {11'd0, bus.Valid}, 12'd1);
    chk("t5_letter", {9'd0, bus.Letter}, 12'd4);

    // 6: all eight codes back-to-back
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      arm();
      send_frame(table_codes[k], 2);
      @(negedge clk);
      chk($sformatf("t6_valid%0d", k), {11'd0, bus.Valid}, 12'd1);
      chk($sformatf("t6_letter%0d", k), {9'd0, bus.Letter}, 12'(k));
      chk($sformatf("t6_error%0d", k), {11'd0, bus.Error}, 12'd0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("valid_pulses", 12'(valid_seen), 12'd10);
    chk("error_pulses", 12'(error_seen), 12'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
